// File: rtl/data_ram_responder.sv
// data_ram_responder
//   Responder end of the core's load/store memory port. A byte-addressed,
//   little-endian data RAM that serves byte, halfword and word loads and
//   stores over a valid/ready request channel and returns exactly one
//   response per request, one cycle after acceptance. Loads are sign- or
//   zero-extended; illegal sizes, misaligned and out-of-range accesses are
//   rejected with rsp_error and never modify the RAM.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset (RAM contents are kept)
//   req_valid    request present
//   req_ready    responder can accept a request this cycle
//   req_write    1 = store, 0 = load
//   req_addr     byte address (WIDTH bits, compared in full for range)
//   req_size     0 = byte, 1 = halfword, 2 = word, 3 = illegal
//   req_unsigned loads only: 1 = zero-extend, 0 = sign-extend
//   req_wdata    right-aligned store data
//   rsp_valid    response present
//   rsp_ready    initiator accepts the response
//   rsp_rdata    extended load result; 0 for stores and errors
//   rsp_error    access was rejected
module data_ram_responder #(
    parameter int WIDTH    = 32,
    parameter int BYTE     = 8,
    parameter int RAM_SIZE = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_error
);

    localparam int LANES = WIDTH / BYTE;
    localparam int DEPTH = RAM_SIZE / 4;
    localparam int AW    = $clog2(RAM_SIZE);
    localparam int SHW   = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] RAM_LIMIT = WIDTH'(RAM_SIZE);

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic                 accept;
    logic [WIDTH-1:0]     mem [DEPTH];
    logic [1:0]           lane;
    logic [AW-3:0]        word_idx;
    logic [SHW-1:0]       shift_amt;
    logic                 size_err, align_err, range_err, req_err;
    logic [WIDTH-1:0]     rd_word, rd_shifted, load_data, wr_data;
    logic [LANES-1:0]     byte_en;

    // ------------------------------------------------------------------
    // Handshake FSM. Next state is derived from req_valid/rsp_ready
    // directly rather than from 'accept' so req_ready does not feed back
    // into the block that produces it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                // A new request may be taken in the same cycle the
                // current response drains.
                req_ready = rsp_ready;
                if (rsp_ready && !req_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign accept = req_valid && req_ready;

    // ------------------------------------------------------------------
    // Address decode and access checks
    // ------------------------------------------------------------------
    assign lane      = req_addr[1:0];
    assign word_idx  = req_addr[AW-1:2];
    assign shift_amt = SHW'(lane) * SHW'(BYTE);

    assign size_err  = (req_size == 2'd3);
    assign align_err = ((req_size == 2'd1) && req_addr[0]) ||
                       ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
    assign range_err = (req_addr >= RAM_LIMIT);
    assign req_err   = size_err || align_err || range_err;

    // ------------------------------------------------------------------
    // Load path: shift the addressed lane(s) down to bit 0, then extend.
    // Word accesses are aligned, so the shift is zero for them.
    // ------------------------------------------------------------------
    assign rd_word    = mem[word_idx];
    assign rd_shifted = rd_word >> shift_amt;

    always_comb begin
        load_data = '0;
        case (req_size)
            2'd0: load_data = {{(WIDTH-BYTE){rd_shifted[BYTE-1] & ~req_unsigned}},
                               rd_shifted[BYTE-1:0]};
            2'd1: load_data = {{(WIDTH-2*BYTE){rd_shifted[2*BYTE-1] & ~req_unsigned}},
                               rd_shifted[2*BYTE-1:0]};
            default: load_data = rd_shifted;
        endcase
    end

    // ------------------------------------------------------------------
    // Store path: move the right-aligned store data up to the addressed
    // lane and enable only the lanes covered by the access size.
    // ------------------------------------------------------------------
    assign wr_data = req_wdata << shift_amt;

    always_comb begin
        byte_en = '0;
        case (req_size)
            2'd0:    byte_en = LANES'(1) << lane;
            2'd1:    byte_en = LANES'(3) << lane;
            2'd2:    byte_en = '1;
            default: byte_en = '0;
        endcase
    end

    // RAM contents are deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (accept && req_write && !req_err) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][i*BYTE +: BYTE] <= wr_data[i*BYTE +: BYTE];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response registers: only loaded on acceptance, so they hold steady
    // under backpressure.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else if (accept) begin
            rsp_error <= req_err;
            rsp_rdata <= (req_err || req_write) ? '0 : load_data;
        end
    end

endmodule

// File: tb/tb_data_ram_responder.sv
// tb_data_ram_responder
//   Self-checking bench for data_ram_responder. A byte-array reference model
//   tracks RAM contents and the single outstanding response; a compare
//   process checks the DUT against it on every falling edge. Directed
//   transfers pin the model with literal expectations, followed by a
//   randomized phase with random backpressure.
module tb_data_ram_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int n_checks = 0;
    int n_fail   = 0;

    data_ram_responder #(
        .WIDTH   (32),
        .BYTE    (8),
        .RAM_SIZE(128)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: RAM as plain bytes, one pending response.
    // ------------------------------------------------------------------
    logic [7:0]  mem_m [0:127];
    logic        m_valid;
    logic [31:0] m_rdata;
    logic        m_err;
    logic        exp_rdy;
    logic [31:0] mod_rd;
    logic        mod_e;

    function automatic void model_eval(input logic w, input logic [31:0] a,
                                       input logic [1:0] sz, input logic u,
                                       output logic [31:0] rd, output logic e);
        int n;
        n  = 1 << sz;
        e  = (sz == 2'd3) || ((a % 32'(n)) != 0) || (a >= 32'd128);
        rd = '0;
        if (!e && !w) begin
            for (int i = 0; i < n; i++) begin
                rd = rd | (32'(mem_m[a + 32'(i)]) << (8 * i));
            end
            if (!u && sz == 2'd0 && rd[7])  rd = rd | 32'hFFFF_FF00;
            if (!u && sz == 2'd1 && rd[15]) rd = rd | 32'hFFFF_0000;
        end
    endfunction

    always_comb begin
        exp_rdy = !m_valid || rsp_ready;
        model_eval(req_write, req_addr, req_size, req_unsigned, mod_rd, mod_e);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_rdata <= '0;
            m_err   <= 1'b0;
        end else if (req_valid && exp_rdy) begin
            m_valid <= 1'b1;
            m_rdata <= mod_rd;
            m_err   <= mod_e;
            if (!mod_e && req_write) begin
                for (int i = 0; i < 4; i++) begin
                    if (i < (1 << req_size)) begin
                        mem_m[req_addr + 32'(i)] <= req_wdata[8*i +: 8];
                    end
                end
            end
        end else if (rsp_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Continuous compare, away from the active edge.
    always @(negedge clk) begin
        chk("cmp_req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("cmp_rsp_valid", 32'(rsp_valid), 32'(m_valid));
        if (m_valid) begin
            chk("cmp_rsp_rdata", rsp_rdata, m_rdata);
            chk("cmp_rsp_error", 32'(rsp_error), 32'(m_err));
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic xfer(input logic w, input logic [31:0] a, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_e, input string nm);
        @(posedge clk); #1;
        req_valid    = 1'b1;
        req_write    = w;
        req_addr     = a;
        req_size     = sz;
        req_unsigned = u;
        req_wdata    = wd;
        rsp_ready    = 1'b1;
        @(negedge clk);
        chk({nm, "_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        @(negedge clk);
        chk({nm, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({nm, "_rdata"}, rsp_rdata, exp_rd);
        chk({nm, "_error"}, 32'(rsp_error), 32'(exp_e));
    endtask

    function automatic logic [31:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b ^ 8'hC3, b, b + 8'h80, ~b};
    endfunction

    logic [31:0] bp_val [4];

    initial begin
        bp_val[0] = 32'h0000_0011;
        bp_val[1] = 32'h8000_0022;
        bp_val[2] = 32'hFFFF_0033;
        bp_val[3] = 32'h1234_5678;

        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = '0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_wdata    = '0;
        rsp_ready    = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_error", 32'(rsp_error), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Fill every word so all later loads read defined data.
        for (int i = 0; i < 32; i++) begin
            xfer(1'b1, 32'(4 * i), 2'd2, 1'b0, pat(i), 32'd0, 1'b0, "init_sw");
        end

        // Word round trip
        xfer(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b0, "sw_10");
        xfer(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, "lw_10");

        // Byte and halfword lanes
        xfer(1'b1, 32'h04, 2'd2, 1'b0, 32'h1122_3344, 32'd0, 1'b0, "sw_04");
        xfer(1'b1, 32'h05, 2'd0, 1'b0, 32'hFFFF_FFA5, 32'd0, 1'b0, "sb_05");
        xfer(1'b0, 32'h04, 2'd2, 1'b0, 32'h0, 32'h1122_A544, 1'b0, "lw_04a");
        xfer(1'b0, 32'h05, 2'd0, 1'b0, 32'h0, 32'hFFFF_FFA5, 1'b0, "lb_05");
        xfer(1'b0, 32'h05, 2'd0, 1'b1, 32'h0, 32'h0000_00A5, 1'b0, "lbu_05");
        xfer(1'b1, 32'h06, 2'd1, 1'b0, 32'h0000_8001, 32'd0, 1'b0, "sh_06");
        xfer(1'b0, 32'h06, 2'd1, 1'b0, 32'h0, 32'hFFFF_8001, 1'b0, "lh_06");
        xfer(1'b0, 32'h06, 2'd1, 1'b1, 32'h0, 32'h0000_8001, 1'b0, "lhu_06");
        xfer(1'b0, 32'h04, 2'd2, 1'b0, 32'h0, 32'h8001_A544, 1'b0, "lw_04b");

        // Errors and range boundary
        xfer(1'b0, 32'h03, 2'd1, 1'b0, 32'h0, 32'd0, 1'b1, "lh_03_misalign");
        xfer(1'b1, 32'h12, 2'd2, 1'b0, 32'h5555_AAAA, 32'd0, 1'b1, "sw_12_misalign");
        xfer(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, "lw_10_unchanged");
        xfer(1'b0, 32'h80, 2'd2, 1'b0, 32'h0, 32'd0, 1'b1, "lw_80_range");
        xfer(1'b0, 32'h7C, 2'd2, 1'b0, 32'h0, 32'hDC1F_9FE0, 1'b0, "lw_7c_last");
        xfer(1'b0, 32'h1000_0010, 2'd2, 1'b0, 32'h0, 32'd0, 1'b1, "lw_noalias");
        xfer(1'b1, 32'h1000_0010, 2'd2, 1'b0, 32'h0BAD_0BAD, 32'd0, 1'b1, "sw_noalias");
        xfer(1'b0, 32'h10, 2'd3, 1'b0, 32'h0, 32'd0, 1'b1, "size3");
        xfer(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, "lw_10_final");

        // Back-to-back: valid held high for four loads
        for (int k = 0; k < 4; k++) begin
            xfer(1'b1, 32'h20 + 32'(4 * k), 2'd2, 1'b0, bp_val[k], 32'd0, 1'b0, "bp_sw");
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            req_valid = 1'b1;
            req_write = 1'b0;
            req_size  = 2'd2;
            req_addr  = 32'h20 + 32'(4 * k);
            rsp_ready = 1'b1;
            @(negedge clk);
            chk("b2b_ready", 32'(req_ready), 32'd1);
            if (k > 0) begin
                chk("b2b_valid", 32'(rsp_valid), 32'd1);
                chk("b2b_rdata", rsp_rdata, bp_val[k-1]);
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_valid_last", 32'(rsp_valid), 32'd1);
        chk("b2b_rdata_last", rsp_rdata, bp_val[3]);

        // Backpressure: response held, next request waits
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h20;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_addr = 32'h24;
        repeat (3) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rdata", rsp_rdata, bp_val[0]);
            chk("bp_error", 32'(rsp_error), 32'd0);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(req_ready), 32'd1);
        chk("bp_release_rdata", rsp_rdata, bp_val[0]);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_valid", 32'(rsp_valid), 32'd1);
        chk("bp_next_rdata", rsp_rdata, bp_val[1]);

        // Reset while a response is stalled
        xfer(1'b1, 32'h30, 2'd2, 1'b0, 32'hCAFE_F00D, 32'd0, 1'b0, "sw_30");
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h30;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_pre_valid", 32'(rsp_valid), 32'd1);
        chk("rst_pre_rdata", rsp_rdata, 32'hCAFE_F00D);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(rsp_valid), 32'd0);
        chk("rst_async_rdata", rsp_rdata, 32'd0);
        chk("rst_async_error", 32'(rsp_error), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rst_post_ready", 32'(req_ready), 32'd1);
        chk("rst_post_valid", 32'(rsp_valid), 32'd0);
        xfer(1'b0, 32'h30, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, "lw_30_kept");
        xfer(1'b0, 32'h06, 2'd1, 1'b1, 32'h0, 32'h0000_8001, 1'b0, "lhu_06_kept");

        // Randomized traffic with random backpressure
        repeat (2000) begin
            int r;
            int r2;
            @(posedge clk); #1;
            req_valid    = ($urandom_range(0, 3) != 0);
            rsp_ready    = ($urandom_range(0, 3) != 0);
            req_write    = $urandom_range(0, 1) == 1;
            req_unsigned = $urandom_range(0, 1) == 1;
            req_wdata    = $urandom;
            r = $urandom_range(0, 9);
            req_size = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            r2 = $urandom_range(0, 9);
            if (r2 == 0) begin
                req_addr = $urandom;
            end else begin
                req_addr = 32'($urandom_range(0, 131));
                if (r2 > 2 && req_size != 2'd3) begin
                    req_addr = req_addr & ~((32'd1 << req_size) - 32'd1);
                end
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
